// File: rtl/dpr_fifo_sync.sv
// rtl/dpr_fifo_sync.sv - synchronous FIFO on a dual-port array with occupancy, flags and error pulses
module dpr_fifo_sync #(
  parameter int MEM_WIDTH       = 16,
  parameter int MEM_DEPTH       = 1024,
  parameter int ADDR_SIZE       = 10,
  parameter int ALMOST_FULL_TH  = MEM_DEPTH - 1,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 blk_select,
  input  logic [MEM_WIDTH-1:0] din,
  input  logic                 wr_en,
  input  logic                 rd_en,
  output logic [MEM_WIDTH-1:0] dout,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 wr_ack,
  output logic                 overflow,
  output logic                 underflow
);

  localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE+1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE:0] AF_TH_C = (ADDR_SIZE+1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_SIZE:0] AE_TH_C = (ADDR_SIZE+1)'(ALMOST_EMPTY_TH);

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic                 we;
  logic                 re;
  logic                 wr_ok;
  logic                 rd_ok;

  assign we    = blk_select & wr_en;
  assign re    = blk_select & rd_en;
  assign wr_ok = we & ~full;
  assign rd_ok = re & ~empty;

  // Flags decode the registered count directly, so they carry no extra latency.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_TH_C);
  assign almost_empty = (count <= AE_TH_C);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // MEM_DEPTH is a power of two, so pointer wrap is the natural rollover.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dout      <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_ok;
      overflow  <= we & full;
      underflow <= re & empty;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
